// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/almost-empty thresholds
// and overflow/underflow pulses. Define FIFO_REG_OUT_EN for a registered read; otherwise show-ahead.
module param_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_TH   = 2**ADDR_WIDTH - 2,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_TH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  push_ok, pop_ok;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  always_comb begin
    push_ok     = push && (!full || pop);
    pop_ok      = pop && !empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = push && !push_ok;
    underflow_d = pop && !pop_ok;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem[wr_ptr_q] <= wdata;
  end

`ifdef FIFO_REG_OUT_EN
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = pop_ok;
    if (pop_ok) rdata_d = mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`else
  assign rdata  = empty ? '0 : mem[rd_ptr_q];
  assign rvalid = !empty;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo (default parameters); follows FIFO_REG_OUT_EN
// to pick show-ahead or registered read expectations.
module tb_param_fifo;

  logic       clk;
  logic       rst_n;
  logic       push;
  logic [7:0] wdata;
  logic       pop;
  logic [7:0] rdata;
  logic       rvalid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int tests_run = 0;
  int tests_failed = 0;

  param_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .wdata        (wdata),
    .pop          (pop),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive inputs at a falling edge; the next rising edge samples them; return at the following falling edge.
  task automatic applyStimulus(input logic r, input logic p, input logic [7:0] d, input logic q);
    rst_n = r;
    push  = p;
    wdata = d;
    pop   = q;
    @(negedge clk);
    push  = 1'b0;
    pop   = 1'b0;
  endtask

  // Pop (optionally with a simultaneous push) and check the popped word against exp.
  task automatic readCheck(input string tag, input logic [7:0] exp, input logic p, input logic [7:0] d);
`ifdef FIFO_REG_OUT_EN
    applyStimulus(1'b1, p, d, 1'b1);
    checkOutput(tag, rdata, exp);
    checkOutput({tag, "_rvalid"}, rvalid, 1'b1);
`else
    checkOutput(tag, rdata, exp);
    checkOutput({tag, "_rvalid"}, rvalid, 1'b1);
    applyStimulus(1'b1, p, d, 1'b1);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    push  = 1'b0;
    wdata = 8'h00;
    pop   = 1'b0;

    // Reset held with push active: nothing may be written.
    applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0);
    checkOutput("rst_count", count, 5'd0);
    checkOutput("rst_empty", empty, 1'b1);
    checkOutput("rst_aempty", almost_empty, 1'b1);
    checkOutput("rst_full", full, 1'b0);
    checkOutput("rst_afull", almost_full, 1'b0);
    checkOutput("rst_rdata", rdata, 8'h00);
    checkOutput("rst_rvalid", rvalid, 1'b0);
    checkOutput("rst_ovf", overflow, 1'b0);
    checkOutput("rst_udf", underflow, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("idle_count", count, 5'd0);

    // Fill with 0x00..0x0F, checking flag boundaries at each step.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(i), 1'b0);
      checkOutput("fill_count", count, 32'(i + 1));
      checkOutput("fill_afull", almost_full, (i + 1) >= 14);
      checkOutput("fill_full", full, (i + 1) == 16);
      checkOutput("fill_aempty", almost_empty, (i + 1) <= 2);
      checkOutput("fill_empty", empty, 1'b0);
    end

    // Push into full FIFO without pop.
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
    checkOutput("ovf_pulse", overflow, 1'b1);
    checkOutput("ovf_count", count, 5'd16);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("ovf_clear", overflow, 1'b0);

    for (int i = 0; i < 16; i++) readCheck("drain_data", 8'(i), 1'b0, 8'h00);
    checkOutput("drain_empty", empty, 1'b1);
    checkOutput("drain_count", count, 5'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("drain_rvalid", rvalid, 1'b0);

    // Plain pop at empty.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("udf_pulse", underflow, 1'b1);
    checkOutput("udf_count", count, 5'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("udf_clear", underflow, 1'b0);

    // Push and pop together at empty: push wins, pop underflows.
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b1);
    checkOutput("pp_empty_udf", underflow, 1'b1);
    checkOutput("pp_empty_count", count, 5'd1);
    checkOutput("pp_empty_ovf", overflow, 1'b0);
    readCheck("pp_empty_data", 8'h5A, 1'b0, 8'h00);
    checkOutput("pp_empty_udf_clr", underflow, 1'b0);
    checkOutput("pp_empty_count0", count, 5'd0);

    // Fill, then stream push+pop at full across the address wrap.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 8'(i), 1'b0);
    checkOutput("wrap_full", full, 1'b1);
    for (int i = 0; i < 20; i++) begin
      readCheck("wrap_data", (i < 16) ? 8'(i) : 8'(8'h10 + i - 16), 1'b1, 8'(8'h10 + i));
      checkOutput("wrap_count", count, 5'd16);
      checkOutput("wrap_ovf", overflow, 1'b0);
    end
    for (int i = 0; i < 16; i++) readCheck("wrap_tail", 8'(8'h14 + i), 1'b0, 8'h00);
    checkOutput("wrap_empty", empty, 1'b1);

    // Reset with seven entries queued discards them.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
    checkOutput("mid_count7", count, 5'd7);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("mid_rst_count", count, 5'd0);
    checkOutput("mid_rst_empty", empty, 1'b1);
    checkOutput("mid_rst_rvalid", rvalid, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h33, 1'b0);
    checkOutput("mid_count1", count, 5'd1);
    readCheck("mid_data", 8'h33, 1'b0, 8'h00);
    checkOutput("mid_final_empty", empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
# param_fifo

Parametrised synchronous FIFO: the next generation of the UART path's 8-bit/16-entry register file plus pointer logic, merged into one self-contained block. Width and depth are configurable, with occupancy count, programmable almost-full/almost-empty thresholds, and overflow/underflow error pulses. It sits between the UART RX/TX engines and the command/loopback logic, and can be used as a general-purpose buffer anywhere in the design.

## Interface
- DATA_WIDTH, 8, bits per entry
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries (ADDR_WIDTH ≥ 2)
- AFULL_TH, 2**ADDR_WIDTH - 2, almost_full asserted when count ≥ AFULL_TH
- AEMPTY_TH, 2, almost_empty asserted when count ≤ AEMPTY_TH

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- push  in  1  write request
- wdata  in  DATA_WIDTH  write data, sampled on accepted push
- pop  in  1  read request
- rdata  out  DATA_WIDTH  read data (timing per Configuration)
- rvalid  out  1  rdata holds a valid popped/head entry
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: push rejected
- underflow  out  1  one-cycle pulse: pop rejected

## Operation
- State: storage array mem[0:DEPTH-1] (not reset), wr_ptr and rd_ptr (ADDR_WIDTH bits), count register (ADDR_WIDTH+1 bits).
- Accepted push: push && (!full || pop). mem[wr_ptr] ← wdata, wr_ptr ← wr_ptr+1 mod DEPTH.
- Accepted pop: pop && !empty. rd_ptr ← rd_ptr+1 mod DEPTH.
- count: +1 on push-only, −1 on pop-only, unchanged on both or neither.
- Full with push+pop: both accepted, count stays DEPTH, no overflow.
- Empty with push+pop: push accepted, pop rejected, underflow pulses, count → 1.
- Rejected push (full, no pop): memory/pointers unchanged, overflow = 1 for the next cycle only.
- Rejected pop (empty): pointers unchanged, underflow = 1 for the next cycle only.
- Pointer wrap is natural binary rollover; no extra wrap bit is needed because count disambiguates full/empty.
- Flags (full, empty, almost_*) are decoded combinationally from the registered count, so they are glitch-free per cycle.

## Timing
- Reset (rst_n low at rising edge): wr_ptr = rd_ptr = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = underflow = 0, rdata = 0, rvalid = 0. Reset overrides push/pop in the same cycle. Mid-operation reset discards all content; mem is not cleared.
- Push at edge N: count/flags reflect the new entry after edge N. No write-to-read bypass within the same cycle.
- overflow/underflow: registered, high for exactly the cycle after the offending edge.

## Configuration
- FIFO_REG_OUT_EN defined: registered (BRAM-inferable) read. On an accepted pop at edge N, rdata ← mem[rd_ptr] and rvalid ← 1 at edge N. Otherwise rvalid ← 0 and rdata holds its value. One-cycle pop-to-data latency.
- Not defined: show-ahead (first-word fall-through) mode. rdata = mem[rd_ptr] combinationally when !empty, and rdata = 0 when empty; rvalid = !empty. Pop consumes the currently presented word. Zero latency; the array infers as distributed RAM.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles with push=1, wdata=8'hAA -> count=0, empty=1, almost_empty=1, rdata=0, rvalid=0, no write occurs.
- Fill/drain, defaults: push 8'h00..8'h0F over 16 cycles -> full=1, count=16, almost_full from count 14. Pop 16 -> data 8'h00..8'h0F in order (show-ahead: on rdata before each pop; REG_OUT: one cycle after each pop). empty=1 at the end.
- Overflow: with the FIFO full, push 8'hFF with no pop -> overflow high for 1 cycle, count stays 16, subsequent pops never return 8'hFF.
- Underflow plus simultaneous ops at empty: push 8'h5A and pop in the same cycle -> underflow for 1 cycle, count=1, next pop returns 8'h5A.
- Simultaneous push and pop at full and pointer wrap: fill 16, then 20 cycles of push(8'h10+i) with pop -> count stays 16, no overflow, output sequence continues 8'h00, 8'h01, …, verifying wrap past address 15.
- Reset mid-stream: with count=7, drive rst_n=0 for 1 cycle -> count=0, empty=1. Push 8'h33, then pop -> returns 8'h33, not stale data.
